// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus: instruction-memory address/data, pipeline control
// and the registered IF/ID instruction bundle.
interface fetch_pc_unit_if;
    logic        stall;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic [15:0] memInstruction;
    logic [31:0] readAddress;
    logic [15:0] ifInstr;
    logic [15:0] ifImm;
    logic [31:0] ifPc;
    logic        ifValid;

    modport master (
        input  stall, branchTaken, branchTarget, memInstruction,
        output readAddress, ifInstr, ifImm, ifPc, ifValid
    );

    modport slave (
        output stall, branchTaken, branchTarget, memInstruction,
        input  readAddress, ifInstr, ifImm, ifPc, ifValid
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program counter and fetch sequencer: assembles one- or two-word
// instructions from a combinational instruction memory into IF/ID.
//
//  state  | meaning
//  -------+----------------------------------------------------------
//  ST_OP  | next word is an opcode; decode it for a trailing immediate
//  ST_IMM | next word is the immediate of the opcode held in op_reg_q
module fetch_pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [2:0]  IMM_OPC      = 3'b011
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_pc_unit_if.master   bus
);

    localparam logic [0:0] ST_OP  = 1'b0;
    localparam logic [0:0] ST_IMM = 1'b1;

    logic [31:0] pc_q, pc_d;
    logic [0:0]  state_q, state_d;
    logic [15:0] op_reg_q, op_reg_d;
    logic [31:0] op_pc_q, op_pc_d;
    logic [15:0] if_instr_q, if_instr_d;
    logic [15:0] if_imm_q, if_imm_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        if_valid_q, if_valid_d;

    always_comb begin
        pc_d       = pc_q;
        state_d    = state_q;
        op_reg_d   = op_reg_q;
        op_pc_d    = op_pc_q;
        if_instr_d = if_instr_q;
        if_imm_d   = if_imm_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;

        // A redirect wins over stall and drops any half-assembled instruction.
        if (bus.branchTaken) begin
            pc_d       = bus.branchTarget;
            state_d    = ST_OP;
            op_reg_d   = 16'h0000;
            if_instr_d = 16'h0000;
            if_imm_d   = 16'h0000;
            if_valid_d = 1'b0;
        end else if (!bus.stall) begin
            pc_d = pc_q + 32'd1;
            case (state_q)
                ST_OP: begin
                    if (bus.memInstruction[15:13] == IMM_OPC) begin
                        op_reg_d   = bus.memInstruction;
                        op_pc_d    = pc_q;
                        if_valid_d = 1'b0;
                        state_d    = ST_IMM;
                    end else begin
                        if_instr_d = bus.memInstruction;
                        if_imm_d   = 16'h0000;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                    end
                end
                ST_IMM: begin
                    if_instr_d = op_reg_q;
                    if_imm_d   = bus.memInstruction;
                    if_pc_d    = op_pc_q;
                    if_valid_d = 1'b1;
                    state_d    = ST_OP;
                end
                default: state_d = ST_OP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_VECTOR;
            state_q    <= ST_OP;
            op_reg_q   <= 16'h0000;
            op_pc_q    <= 32'h0000_0000;
            if_instr_q <= 16'h0000;
            if_imm_q   <= 16'h0000;
            if_pc_q    <= 32'h0000_0000;
            if_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            state_q    <= state_d;
            op_reg_q   <= op_reg_d;
            op_pc_q    <= op_pc_d;
            if_instr_q <= if_instr_d;
            if_imm_q   <= if_imm_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
        end
    end

    assign bus.readAddress = pc_q;
    assign bus.ifInstr     = if_instr_q;
    assign bus.ifImm       = if_imm_q;
    assign bus.ifPc        = if_pc_q;
    assign bus.ifValid     = if_valid_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit; observed bundle is
// {ifValid, ifInstr, ifImm, ifPc, readAddress}.
module tb_fetch_pc_unit;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    fetch_pc_unit_if bus ();

    fetch_pc_unit #(
        .RESET_VECTOR (32'h0000_0000),
        .IMM_OPC      (3'b011)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [31:0] a);
        case (a)
            32'd0:         mem_word = 16'h1234;
            32'd1:         mem_word = 16'h2001;
            32'd3:         mem_word = 16'h4321;
            32'd4:         mem_word = 16'h6ABC;
            32'd5:         mem_word = 16'h00FF;
            32'd8:         mem_word = 16'h7000;
            32'd9:         mem_word = 16'hBEEF;
            32'd20:        mem_word = 16'hA55A;
            32'hFFFF_FFFF: mem_word = 16'h0000;
            default:       mem_word = 16'h5555;
        endcase
    endfunction

    // Memory returns 0 while stalled.
    assign bus.memInstruction = bus.stall ? 16'h0000 : mem_word(bus.readAddress);

    wire [96:0] obs = {bus.ifValid, bus.ifInstr, bus.ifImm, bus.ifPc, bus.readAddress};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n            = 1'b1;
        bus.stall        = 1'b0;
        bus.branchTaken  = 1'b0;
        bus.branchTarget = 32'h0;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (obs !== {1'b0, 16'h0, 16'h0, 32'h0, 32'h0}) begin
            fails++;
            $display("FAIL reset_async got=%h exp=%h", obs, {1'b0, 16'h0, 16'h0, 32'h0, 32'h0});
        end
        step();
        step();
        tests++;
        if (obs !== {1'b0, 16'h0, 16'h0, 32'h0, 32'h0}) begin
            fails++;
            $display("FAIL reset_held got=%h exp=%h", obs, {1'b0, 16'h0, 16'h0, 32'h0, 32'h0});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_one_word();
        step();
        tests++;
        if (obs !== {1'b1, 16'h1234, 16'h0, 32'h0, 32'h1}) begin
            fails++;
            $display("FAIL one_word_0 got=%h exp=%h", obs, {1'b1, 16'h1234, 16'h0, 32'h0, 32'h1});
        end
        step();
        tests++;
        if (obs !== {1'b1, 16'h2001, 16'h0, 32'h1, 32'h2}) begin
            fails++;
            $display("FAIL one_word_1 got=%h exp=%h", obs, {1'b1, 16'h2001, 16'h0, 32'h1, 32'h2});
        end
    endtask

    task automatic test_two_word();
        bus.branchTaken  = 1'b1;
        bus.branchTarget = 32'd4;
        step();
        bus.branchTaken = 1'b0;
        tests++;
        if (obs !== {1'b0, 16'h0, 16'h0, 32'h1, 32'h4}) begin
            fails++;
            $display("FAIL two_word_branch got=%h exp=%h", obs, {1'b0, 16'h0, 16'h0, 32'h1, 32'h4});
        end
        step();
        tests++;
        if (obs !== {1'b0, 16'h0, 16'h0, 32'h1, 32'h5}) begin
            fails++;
            $display("FAIL two_word_opcode got=%h exp=%h", obs, {1'b0, 16'h0, 16'h0, 32'h1, 32'h5});
        end
        step();
        tests++;
        if (obs !== {1'b1, 16'h6ABC, 16'h00FF, 32'h4, 32'h6}) begin
            fails++;
            $display("FAIL two_word_emit got=%h exp=%h", obs, {1'b1, 16'h6ABC, 16'h00FF, 32'h4, 32'h6});
        end
    endtask

    task automatic test_stall();
        bus.branchTaken  = 1'b1;
        bus.branchTarget = 32'd3;
        step();
        bus.branchTaken = 1'b0;
        step();
        tests++;
        if (obs !== {1'b1, 16'h4321, 16'h0, 32'h3, 32'h4}) begin
            fails++;
            $display("FAIL stall_setup got=%h exp=%h", obs, {1'b1, 16'h4321, 16'h0, 32'h3, 32'h4});
        end
        step();
        tests++;
        if (obs !== {1'b0, 16'h4321, 16'h0, 32'h3, 32'h5}) begin
            fails++;
            $display("FAIL stall_pre got=%h exp=%h", obs, {1'b0, 16'h4321, 16'h0, 32'h3, 32'h5});
        end
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (obs !== {1'b0, 16'h4321, 16'h0, 32'h3, 32'h5}) begin
                fails++;
                $display("FAIL stall_hold_imm[%0d] got=%h exp=%h", i, obs, {1'b0, 16'h4321, 16'h0, 32'h3, 32'h5});
            end
        end
        bus.stall = 1'b0;
        step();
        tests++;
        if (obs !== {1'b1, 16'h6ABC, 16'h00FF, 32'h4, 32'h6}) begin
            fails++;
            $display("FAIL stall_resume got=%h exp=%h", obs, {1'b1, 16'h6ABC, 16'h00FF, 32'h4, 32'h6});
        end
        bus.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            tests++;
            if (obs !== {1'b1, 16'h6ABC, 16'h00FF, 32'h4, 32'h6}) begin
                fails++;
                $display("FAIL stall_hold_valid[%0d] got=%h exp=%h", i, obs, {1'b1, 16'h6ABC, 16'h00FF, 32'h4, 32'h6});
            end
        end
        bus.stall = 1'b0;
    endtask

    task automatic test_branch_in_imm();
        bus.branchTaken  = 1'b1;
        bus.branchTarget = 32'd8;
        step();
        bus.branchTaken = 1'b0;
        step();
        tests++;
        if (obs !== {1'b0, 16'h0, 16'h0, 32'h4, 32'h9}) begin
            fails++;
            $display("FAIL branch_imm_opcode got=%h exp=%h", obs, {1'b0, 16'h0, 16'h0, 32'h4, 32'h9});
        end
        bus.branchTaken  = 1'b1;
        bus.branchTarget = 32'd20;
        bus.stall        = 1'b1;
        step();
        bus.branchTaken = 1'b0;
        bus.stall       = 1'b0;
        tests++;
        if (obs !== {1'b0, 16'h0, 16'h0, 32'h4, 32'd20}) begin
            fails++;
            $display("FAIL branch_imm_redirect got=%h exp=%h", obs, {1'b0, 16'h0, 16'h0, 32'h4, 32'd20});
        end
        step();
        tests++;
        if (obs !== {1'b1, 16'hA55A, 16'h0, 32'd20, 32'd21}) begin
            fails++;
            $display("FAIL branch_imm_target got=%h exp=%h", obs, {1'b1, 16'hA55A, 16'h0, 32'd20, 32'd21});
        end
    endtask

    task automatic test_wrap();
        bus.branchTaken  = 1'b1;
        bus.branchTarget = 32'hFFFF_FFFF;
        step();
        bus.branchTaken = 1'b0;
        step();
        tests++;
        if (obs !== {1'b1, 16'h0000, 16'h0, 32'hFFFF_FFFF, 32'h0}) begin
            fails++;
            $display("FAIL wrap_nop got=%h exp=%h", obs, {1'b1, 16'h0000, 16'h0, 32'hFFFF_FFFF, 32'h0});
        end
    endtask

    task automatic test_reset_mid_run();
        step();
        tests++;
        if (obs !== {1'b1, 16'h1234, 16'h0, 32'h0, 32'h1}) begin
            fails++;
            $display("FAIL mid_run_pre got=%h exp=%h", obs, {1'b1, 16'h1234, 16'h0, 32'h0, 32'h1});
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (obs !== {1'b0, 16'h0, 16'h0, 32'h0, 32'h0}) begin
            fails++;
            $display("FAIL mid_run_reset got=%h exp=%h", obs, {1'b0, 16'h0, 16'h0, 32'h0, 32'h0});
        end
        step();
        rst_n = 1'b1;
        step();
        tests++;
        if (obs !== {1'b1, 16'h1234, 16'h0, 32'h0, 32'h1}) begin
            fails++;
            $display("FAIL mid_run_restart got=%h exp=%h", obs, {1'b1, 16'h1234, 16'h0, 32'h0, 32'h1});
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_one_word();
        test_two_word();
        test_stall();
        test_branch_in_imm();
        test_wrap();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
